instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Sequences instruction fetch from the byte-addressed, combinational-read instruction
//  memory (MEM_BYTES bytes, little-endian 32-bit words). Holds the fetch PC.
//  Prefetches sequential words into a DEPTH-entry queue and presents them to the core
//  through a valid/ready handshake. Handles redirects (branch/jump/trap) and flags
//  out-of-range or misaligned fetches. Sits between the core decode stage and instr_mem.
// PARAMETERS
//  MEM_BYTES  1024  instruction memory size in bytes; last legal word address = MEM_BYTES-4
//  DEPTH      4     prefetch queue entries; power of two, >=2
//  RESET_PC   32'h0 fetch PC after reset; word-aligned
// PORTS
//  clk_i            in   1   clock
//  rst_i            in   1   asynchronous, active-high reset
//  redirect_i       in   1   flush the queue and restart fetch at redirect_pc_i
//  redirect_pc_i    in   32  new fetch PC
//  instr_valid_o    out  1   queue head valid
//  instr_ready_i    in   1   consumer accepts the head this cycle
//  instr_o          out  32  instruction word at the queue head
//  instr_pc_o       out  32  PC of instr_o
//  instr_fault_o    out  1   head entry is a fault marker; instr_o = 0
//  imem_addr_o      out  32  byte address to instr_mem; equals fetch_pc
//  imem_rdata_i     in   32  combinational read data from instr_mem
// BEHAVIOUR
//  - Reset (async, rst_i=1):
//    - fetch_pc=RESET_PC; queue empty; halted=0.
//    - Outputs: instr_valid_o=0, instr_o=0, instr_pc_o=0, instr_fault_o=0, imem_addr_o=RESET_PC.
//  - pop = instr_valid_o & instr_ready_i.
//  - push = !halted & !redirect_i & (count<DEPTH | pop). Full queue with pop in the same cycle still pushes.
//  - Push entry = {pc=fetch_pc, data=imem_rdata_i, fault=0}; then fetch_pc += 4.
//  - Range fault: when fetch_pc > MEM_BYTES-4, the pushed entry is {fetch_pc, 32'h0, fault=1}.
//    Then halted=1 and fetch_pc is held.
//  - Halted: no further pushes until a redirect arrives. Queued entries still drain normally.
//  - Redirect (highest priority):
//    - Next cycle: queue empty, fetch_pc=redirect_pc_i, halted=0. No push or pop takes effect in the redirect cycle.
//    - If redirect_pc_i[1:0] != 0: fetch_pc={redirect_pc_i[31:2],2'b00}. The next push is a fault entry with pc=redirect_pc_i (unaligned). Then halted=1.
//  - Latency: first instr_valid_o one cycle after reset release or redirect. Sustained 1 instr/cycle when ready is held high.
//  - Output ordering: instr_o, instr_pc_o and instr_fault_o come from the registered head and are stable while valid & !ready.
//    Outputs are 0 when the queue is empty.
//  - Wrap-around: the pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
//  - fetch_pc+4 overflow past 32'hFFFF_FFFC is not reachable without a range fault first.
//  - Reset mid-operation clears the queue immediately. No partial entry survives.
// STRUCTURE
//  - fetch_pkg:
//    - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] data; logic fault;}
//    - localparam NOP_INSTR = 32'h0000_0013
//  - Sub-module fetch_queue: sync FIFO of fetch_entry_t, DEPTH entries.
//    - Ports: push, pop, flush, full, empty, count, head.
//    - flush has priority over push/pop.
//  - Top level: fetch_pc register, halted flag, push/fault/redirect logic.
// TESTING
//  - Reset, ready=1, memory holds words 0x11,0x22,0x33 at 0,4,8:
//    -> valid from cycle 1; pc 0,4,8 with data 0x11,0x22,0x33, one per cycle.
//  - ready=0 for 10 cycles after reset:
//    -> count saturates at DEPTH=4; imem_addr_o holds 0x10; head stays pc=0, stable.
//  - Redirect to 0x40 while queue full:
//    -> next cycle valid=0; the cycle after that, head pc=0x40. No stale pc 0x0-0xC is ever emitted.
//  - Sequential fetch reaching 0x3FC then 0x400 (MEM_BYTES=1024):
//    -> entry pc=0x3FC valid with data; entry pc=0x400 has fault=1, data=0.
//    -> No more entries follow; a redirect to 0 resumes fetch.
//  - Redirect to 0x6 (unaligned):
//    -> a single fault entry with pc=0x6, then halted.
//  - Assert rst_i mid-stream with 3 entries queued:
//    -> valid=0 in the same cycle (async); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// Package  : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Purpose  : Synchronous FIFO of fetch entries; flush overrides push and pop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               entry_in,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_entry_t               head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t           storage [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full queue may still accept a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) storage[wr_ptr] <= entry_in;
  end

  assign head = empty ? '0 : storage[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch PC sequencing, prefetch queue, redirect and fault handling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          MEM_BYTES = 1024,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_fault_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  logic [31:0]          fetch_pc;
  logic                 halted;
  logic                 misalign_pending;
  logic [31:0]          misalign_pc;

  logic                 pop;
  logic                 push;
  logic                 range_fault;
  logic                 q_full;
  logic                 q_empty;
  logic [$clog2(DEPTH):0] q_count_unused;
  fetch_entry_t         push_entry;
  fetch_entry_t         head;

  assign pop         = instr_valid_o & instr_ready_i;
  assign push        = ~halted & ~redirect_i & (~q_full | pop);
  assign range_fault = (fetch_pc > LAST_WORD);

  always_comb begin
    push_entry = '{pc: fetch_pc, data: imem_rdata_i, fault: 1'b0};
    // An unaligned redirect reports the original address, not the rounded fetch PC.
    if (misalign_pending) begin
      push_entry = '{pc: misalign_pc, data: 32'h0, fault: 1'b1};
    end else if (range_fault) begin
      push_entry = '{pc: fetch_pc, data: 32'h0, fault: 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc         <= RESET_PC;
      halted           <= 1'b0;
      misalign_pending <= 1'b0;
      misalign_pc      <= 32'h0;
    end else if (redirect_i) begin
      fetch_pc         <= {redirect_pc_i[31:2], 2'b00};
      halted           <= 1'b0;
      misalign_pending <= |redirect_pc_i[1:0];
      misalign_pc      <= redirect_pc_i;
    end else if (push) begin
      if (misalign_pending || range_fault) begin
        halted           <= 1'b1;
        misalign_pending <= 1'b0;
      end else begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_i),
    .entry_in (push_entry),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count_unused),
    .head     (head)
  );

  assign instr_valid_o = ~q_empty;
  assign instr_o       = head.data;
  assign instr_pc_o    = head.pc;
  assign instr_fault_o = head.fault;
  assign imem_addr_o   = fetch_pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(
    .MEM_BYTES (1024),
    .DEPTH     (4),
    .RESET_PC  (32'h0)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_fault_o (fault),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Out-of-range reads return a recognisable pattern so a fault entry must zero it.
  assign imem_rdata = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic ev, input logic [31:0] epc,
                          input logic [31:0] edata, input logic ef);
    checks++;
    if (valid !== ev || instr_pc !== epc || instr !== edata || fault !== ef) begin
      errors++;
      $display("FAIL %s got v=%b pc=%h d=%h f=%b exp v=%b pc=%h d=%h f=%b",
               name, valid, instr_pc, instr, fault, ev, epc, edata, ef);
    end
  endtask

  task automatic do_reset(input logic rdy);
    ready    = rdy;
    redirect = 1'b0;
    rst      = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    step();
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #2;
    chk_head("reset_head", 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr got %h exp %h", imem_addr, 32'h0);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    step();
    chk_head("stream_0", 1'b1, 32'h0, 32'h11, 1'b0);
    step();
    chk_head("stream_4", 1'b1, 32'h4, 32'h22, 1'b0);
    step();
    chk_head("stream_8", 1'b1, 32'h8, 32'h33, 1'b0);
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_head($sformatf("stall_head_%0d", i), 1'b1, 32'h0, 32'h11, 1'b0);
    end
    checks++;
    if (imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL stall_addr got %h exp %h", imem_addr, 32'h10);
    end
  endtask

  task automatic test_redirect_full();
    do_redirect(32'h40);
    chk_head("redir_flush", 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk_head("redir_first", 1'b1, 32'h40, 32'h1000_0010, 1'b0);
    ready = 1'b1;
    step();
    chk_head("redir_second", 1'b1, 32'h44, 32'h1000_0011, 1'b0);
    step();
    chk_head("redir_third", 1'b1, 32'h48, 32'h1000_0012, 1'b0);
  endtask

  task automatic test_range();
    ready = 1'b1;
    do_redirect(32'h3F8);
    chk_head("range_flush", 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk_head("range_3f8", 1'b1, 32'h3F8, 32'h1000_00FE, 1'b0);
    step();
    chk_head("range_3fc", 1'b1, 32'h3FC, 32'h1000_00FF, 1'b0);
    step();
    chk_head("range_fault", 1'b1, 32'h400, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_head($sformatf("range_halted_%0d", i), 1'b0, 32'h0, 32'h0, 1'b0);
    end
    checks++;
    if (imem_addr !== 32'h400) begin
      errors++;
      $display("FAIL range_addr_held got %h exp %h", imem_addr, 32'h400);
    end
    do_redirect(32'h0);
    step();
    chk_head("range_resume", 1'b1, 32'h0, 32'h11, 1'b0);
  endtask

  task automatic test_unaligned();
    ready = 1'b1;
    do_redirect(32'h6);
    chk_head("unal_flush", 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL unal_addr got %h exp %h", imem_addr, 32'h4);
    end
    step();
    chk_head("unal_fault", 1'b1, 32'h6, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_head($sformatf("unal_halted_%0d", i), 1'b0, 32'h0, 32'h0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    do_redirect(32'h80);
    step();
    step();
    step();
    chk_head("mid_queued", 1'b1, 32'h80, 32'h1000_0020, 1'b0);
    rst = 1'b1;
    #1;
    chk_head("mid_async_clear", 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL mid_addr got %h exp %h", imem_addr, 32'h0);
    end
    step();
    rst   = 1'b0;
    ready = 1'b1;
    step();
    chk_head("mid_restart_0", 1'b1, 32'h0, 32'h11, 1'b0);
    step();
    chk_head("mid_restart_4", 1'b1, 32'h4, 32'h22, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;

    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_range();
    test_unaligned();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
